// File: rtl/imem_responder.sv
// Preloadable instruction memory answering fetches in acceptance order, LATENCY cycles after grant.
// Grant drops while MAX_OUTSTANDING responses are in flight; IMEM_STALL_INJECT_EN adds LFSR-driven grant stalls.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          DEPTH_WORDS     = 1024,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        instr_rvalid_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i
);
    localparam int            AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [31:0]              r_mem [DEPTH_WORDS];
    logic [LATENCY-1:0]       r_vld;
    logic [LATENCY-1:0][31:0] r_dat;
    logic [LATENCY-1:0]       r_err;
    logic [CW-1:0]            r_cnt;

    logic [31:0] w_rd_word;
    logic [31:0] w_ld_word;
    logic        w_rd_in;
    logic        w_ld_in;
    logic        w_stall;
    logic        w_accept;
    logic        w_retire;

    // Unsigned wrap makes addresses below BASE_ADDR land far above DEPTH_WORDS.
    assign w_rd_word = (instr_addr_i - BASE_ADDR) >> 2;
    assign w_ld_word = (load_addr_i - BASE_ADDR) >> 2;
    assign w_rd_in   = w_rd_word < 32'(DEPTH_WORDS);
    assign w_ld_in   = w_ld_word < 32'(DEPTH_WORDS);

`ifdef IMEM_STALL_INJECT_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall = r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    assign instr_gnt_o = instr_req_i && (r_cnt < CNT_MAX) && !w_stall;
    assign w_accept    = instr_req_i && instr_gnt_o;
    assign w_retire    = r_vld[LATENCY-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_accept && !w_retire && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_accept && w_retire && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Stage 0 reads the array before this edge's load lands, so a colliding read sees the old word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            r_dat <= '0;
            r_err <= '0;
        end else begin
            r_vld[0] <= w_accept;
            r_err[0] <= w_accept && !w_rd_in;
            r_dat[0] <= (w_accept && w_rd_in) ? r_mem[w_rd_word[AW-1:0]] : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_we_i && w_ld_in) begin
            r_mem[w_ld_word[AW-1:0]] <= load_wdata_i;
        end
    end

    assign instr_rvalid_o = r_vld[LATENCY-1];
    assign instr_err_o    = r_err[LATENCY-1];
    assign instr_rdata_o  = r_dat[LATENCY-1];
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1/2/3) driven by vector tables, corner sequences
// and a randomized run against a queue-based response model.
module tb_imem_responder;
    localparam logic [31:0] C_BASE = 32'h8000_0000;
    localparam int          C_LAT  = 3;
    localparam int          C_MAX  = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        req    [3];
    logic [31:0] addr   [3];
    logic        we     [3];
    logic [31:0] laddr  [3];
    logic [31:0] wdata  [3];
    logic        gnt    [3];
    logic [31:0] rdata  [3];
    logic        err    [3];
    logic        rvalid [3];

    imem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .LATENCY(1), .MAX_OUTSTANDING(1)) u_a (
        .clk(clk), .rstn(rstn), .instr_req_i(req[0]), .instr_gnt_o(gnt[0]), .instr_addr_i(addr[0]),
        .instr_rdata_o(rdata[0]), .instr_err_o(err[0]), .instr_rvalid_o(rvalid[0]),
        .load_we_i(we[0]), .load_addr_i(laddr[0]), .load_wdata_i(wdata[0]));

    imem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .LATENCY(2), .MAX_OUTSTANDING(2)) u_b (
        .clk(clk), .rstn(rstn), .instr_req_i(req[1]), .instr_gnt_o(gnt[1]), .instr_addr_i(addr[1]),
        .instr_rdata_o(rdata[1]), .instr_err_o(err[1]), .instr_rvalid_o(rvalid[1]),
        .load_we_i(we[1]), .load_addr_i(laddr[1]), .load_wdata_i(wdata[1]));

    imem_responder #(.BASE_ADDR(C_BASE), .DEPTH_WORDS(1024), .LATENCY(C_LAT), .MAX_OUTSTANDING(C_MAX)) u_c (
        .clk(clk), .rstn(rstn), .instr_req_i(req[2]), .instr_gnt_o(gnt[2]), .instr_addr_i(addr[2]),
        .instr_rdata_o(rdata[2]), .instr_err_o(err[2]), .instr_rvalid_o(rvalid[2]),
        .load_we_i(we[2]), .load_addr_i(laddr[2]), .load_wdata_i(wdata[2]));

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    int          n_chk  = 0;
    int          n_pass = 0;
    vec_t        tbl [6];
    exp_t        q [$];
    logic [31:0] cmem [16];

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [33:0] rsp(input int k);
        return {rvalid[k], err[k], rdata[k]};
    endfunction

    function automatic logic [33:0] ok_rsp(input logic [31:0] d);
        return {2'b10, d};
    endfunction

    function automatic logic [31:0] pat(input int i);
        return 32'h0000_0513 + 32'(i) * 32'h0101_0100;
    endfunction

    // Word index inside instance C's window, or -1 when the byte address is outside it.
    function automatic int word_of(input logic [31:0] a);
        longint la;
        la = a;
        if (la >= C_BASE && la < C_BASE + 4 * 1024) return int'((la - C_BASE) / 4);
        return -1;
    endfunction

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 5))
            0:       return C_BASE - 32'(4 * $urandom_range(1, 8));
            1:       return C_BASE + 32'h1000 + 32'(4 * $urandom_range(0, 15));
            2:       return 32'(4 * $urandom_range(0, 15));
            default: return C_BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no summary, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{"w0",        32'h0000_0000, pat(0),    1'b0};
        tbl[1] = '{"misalign6", 32'h0000_0006, pat(1),    1'b0};
        tbl[2] = '{"w7_b3",     32'h0000_001F, pat(7),    1'b0};
        tbl[3] = '{"last_word", 32'h0000_0FFC, pat(1023), 1'b0};
        tbl[4] = '{"past_end",  32'h0000_1000, 32'h0,     1'b1};
        tbl[5] = '{"wrap_low",  32'hFFFF_FFFC, 32'h0,     1'b1};

        rstn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; laddr[k] = '0; wdata[k] = '0;
        end
        tick();

        // Preload while held in reset: the array must not depend on reset.
        for (int i = 0; i <= 16; i++) begin
            we[0] = 1'b1;
            laddr[0] = (i == 16) ? 32'h0000_0FFC : 32'(4 * i);
            wdata[0] = (i == 16) ? pat(1023) : ((i == 4) ? 32'h1111_1111 : pat(i));
            we[1] = 1'b1;
            laddr[1] = 32'(4 * i);
            wdata[1] = pat(i) ^ 32'hFFFF_0000;
            we[2] = 1'b1;
            laddr[2] = C_BASE + 32'(4 * i);
            wdata[2] = $urandom;
            if (i < 16) cmem[i] = wdata[2];
            tick();
        end
        for (int k = 0; k < 3; k++) we[k] = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) chk("reset_rsp", rsp(k), 34'h0);

        // First vector runs in the first cycle after release.
        tick();
        rstn = 1'b1;
        for (int v = 0; v < 6; v++) begin
            req[0] = 1'b1; addr[0] = tbl[v].addr;
            #2 chk({tbl[v].name, "_gnt"}, 34'(gnt[0]), 34'h1);
            tick();
            req[0] = 1'b0;
            #2 chk({tbl[v].name, "_rsp"}, rsp(0), {1'b1, tbl[v].err, tbl[v].data});
            tick();
            #2 chk({tbl[v].name, "_idle"}, rsp(0), 34'h0);
        end

        // MAX_OUTSTANDING=1: the retiring cycle still blocks grant.
        tick();
        req[0] = 1'b1; addr[0] = 32'h8;
        #2 chk("hold_gnt0", 34'(gnt[0]), 34'h1);
        tick();
        #2 chk("hold_gnt1_blocked", 34'(gnt[0]), 34'h0);
        chk("hold_rsp1", rsp(0), ok_rsp(pat(2)));
        tick();
        #2 chk("hold_gnt2", 34'(gnt[0]), 34'h1);
        chk("hold_rsp2_idle", rsp(0), 34'h0);
        tick();
        req[0] = 1'b0;
        #2 chk("hold_rsp3", rsp(0), ok_rsp(pat(2)));
        tick();

        // Read and load of the same word on one edge returns the old word.
        req[0] = 1'b1; addr[0] = 32'h10;
        we[0] = 1'b1; laddr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF;
        #2 chk("col_gnt", 34'(gnt[0]), 34'h1);
        tick();
        req[0] = 1'b0;
        laddr[0] = 32'h1010; wdata[0] = 32'hBAD0_0000;
        #2 chk("col_old", rsp(0), ok_rsp(32'h1111_1111));
        tick();
        we[0] = 1'b0;
        req[0] = 1'b1; addr[0] = 32'h10;
        #2 chk("col_new_gnt", 34'(gnt[0]), 34'h1);
        tick();
        req[0] = 1'b0;
        #2 chk("col_new", rsp(0), ok_rsp(32'hDEAD_BEEF));
        tick();

        // LATENCY=2, MAX=2: third request waits for the first retirement.
        req[1] = 1'b1; addr[1] = 32'h0;
        #2 chk("b_gnt0", 34'(gnt[1]), 34'h1);
        tick();
        addr[1] = 32'h4;
        #2 chk("b_gnt1", 34'(gnt[1]), 34'h1);
        chk("b_rsp1_idle", rsp(1), 34'h0);
        tick();
        addr[1] = 32'h8;
        #2 chk("b_gnt2_blocked", 34'(gnt[1]), 34'h0);
        chk("b_rsp_w0", rsp(1), ok_rsp(pat(0) ^ 32'hFFFF_0000));
        tick();
        #2 chk("b_gnt3", 34'(gnt[1]), 34'h1);
        chk("b_rsp_w1", rsp(1), ok_rsp(pat(1) ^ 32'hFFFF_0000));
        tick();
        req[1] = 1'b0;
        #2 chk("b_rsp4_idle", rsp(1), 34'h0);
        tick();
        #2 chk("b_rsp_w2", rsp(1), ok_rsp(pat(2) ^ 32'hFFFF_0000));
        tick();

        // Non-zero base: below-base wrap and past-end both error.
        req[2] = 1'b1; addr[2] = 32'h7FFF_FFFC;
        #2 chk("c_oor_gnt0", 34'(gnt[2]), 34'h1);
        tick();
        addr[2] = 32'h8000_1000;
        #2 chk("c_oor_gnt1", 34'(gnt[2]), 34'h1);
        tick();
        req[2] = 1'b0;
        #2 chk("c_oor_early", rsp(2), 34'h0);
        tick();
        #2 chk("c_oor_below", rsp(2), 34'h2_0000_0000 | 34'h1_0000_0000 << 1 >> 1 | {2'b11, 32'h0});
        tick();
        #2 chk("c_oor_above", rsp(2), {2'b11, 32'h0});
        tick();
        #2 chk("c_oor_after", rsp(2), 34'h0);
        tick();

        // Reset with two requests in flight drops them and clears the counter.
        req[2] = 1'b1; addr[2] = C_BASE;
        #2 chk("c_rst_gnt0", 34'(gnt[2]), 34'h1);
        tick();
        addr[2] = C_BASE + 32'h4;
        #2 chk("c_rst_gnt1", 34'(gnt[2]), 34'h1);
        tick();
        req[2] = 1'b0;
        rstn = 1'b0;
        #2 chk("c_rst_hold", rsp(2), 34'h0);
        tick();
        rstn = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #2 chk("c_rst_dropped", rsp(2), 34'h0);
            tick();
        end
        req[2] = 1'b1; addr[2] = C_BASE + 32'h8;
        #2 chk("c_post_gnt0", 34'(gnt[2]), 34'h1);
        tick();
        addr[2] = C_BASE + 32'hC;
        #2 chk("c_post_gnt1", 34'(gnt[2]), 34'h1);
        tick();
        req[2] = 1'b0;
        #2 chk("c_post_idle", rsp(2), 34'h0);
        tick();
        #2 chk("c_post_w2", rsp(2), ok_rsp(cmem[2]));
        tick();
        #2 chk("c_post_w3", rsp(2), ok_rsp(cmem[3]));
        tick();
        #2 chk("c_post_after", rsp(2), 34'h0);
        tick();

        // Randomized traffic on instance C against an in-order response queue.
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic exp_g;
            int   idx;
            exp_t e;
            req[2]   = (cyc < 394) && ($urandom_range(0, 9) < 7);
            addr[2]  = rnd_addr();
            we[2]    = $urandom_range(0, 9) < 3;
            laddr[2] = rnd_addr();
            wdata[2] = $urandom;
            #2;
            exp_g = req[2] && (q.size() < C_MAX);
            chk("rnd_gnt", 34'(gnt[2]), 34'(exp_g));
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("rnd_rsp", rsp(2), {1'b1, q[0].err, q[0].data});
                void'(q.pop_front());
            end else begin
                chk("rnd_idle", rsp(2), 34'h0);
            end
            if (exp_g) begin
                idx    = word_of(addr[2]);
                e.err  = (idx < 0);
                e.data = (idx < 0) ? 32'h0 : cmem[idx];
                e.due  = cyc + C_LAT;
                q.push_back(e);
            end
            if (we[2]) begin
                idx = word_of(laddr[2]);
                if (idx >= 0) cmem[idx] = wdata[2];
            end
            tick();
        end
        we[2] = 1'b0;
        req[2] = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: array size in 32-bit words, power of two.
REQ-003 SHALL have parameter LATENCY, default 1, legal range 1..4: cycles from grant to rvalid.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, legal range 1..LATENCY: granted requests not yet answered.
REQ-005 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port instr_req_i, input, 1 bit: fetch request.
REQ-008 SHALL have port instr_gnt_o, output, 1 bit: request accepted this cycle.
REQ-009 SHALL have port instr_addr_i, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-010 SHALL have port instr_rdata_o, output, 32 bits: response word.
REQ-011 SHALL have port instr_err_o, output, 1 bit: response error, qualified by rvalid.
REQ-012 SHALL have port instr_rvalid_o, output, 1 bit: response valid for one cycle.
REQ-013 SHALL have ports load_we_i (1), load_addr_i (32), load_wdata_i (32), all inputs: preload write port, byte address, bits [1:0] ignored.

Function
REQ-014 SHALL drive instr_gnt_o combinationally: instr_req_i AND (outstanding count < MAX_OUTSTANDING); a count reaching MAX_OUTSTANDING and retiring in the same cycle SHALL still block the grant.
REQ-015 SHALL treat a cycle with instr_req_i=1 and instr_gnt_o=1 as an accepted request; the address SHALL be sampled at that clock edge.
REQ-016 SHALL read the array at the acceptance edge and assert instr_rvalid_o exactly LATENCY cycles after acceptance, through a LATENCY-stage shift register carrying valid, data, and err.
REQ-017 SHALL return responses strictly in acceptance order; back-to-back accepts SHALL produce back-to-back rvalid pulses.
REQ-018 SHALL compute the word index as (instr_addr_i - BASE_ADDR) >> 2 with 32-bit unsigned arithmetic; an index >= DEPTH_WORDS, including wrap below BASE_ADDR, SHALL be out of range.
REQ-019 SHALL respond to an out-of-range request with instr_err_o=1 and instr_rdata_o=0; in-range requests SHALL return instr_err_o=0.
REQ-020 SHALL hold instr_rdata_o=0 and instr_err_o=0 whenever instr_rvalid_o=0.
REQ-021 SHALL keep a saturating outstanding counter: +1 on accept, -1 on rvalid, unchanged when both occur in the same cycle.
REQ-022 SHALL write load_wdata_i to the array at the edge where load_we_i=1 and the load address is in range; out-of-range loads SHALL be ignored silently.
REQ-023 SHALL return the pre-write (old) word when a read is accepted at the same edge as a load to the same word.

Reset
REQ-024 SHALL, while rstn=0, force instr_rvalid_o=0, instr_err_o=0, instr_rdata_o=0, all pipeline valids to 0, and the outstanding counter to 0.
REQ-025 SHALL drop any in-flight responses when reset is asserted mid-operation; no rvalid for pre-reset requests SHALL appear after release.
REQ-026 SHALL NOT reset array contents.
REQ-027 SHALL allow instr_gnt_o to assert in the first cycle after reset release.

Configuration
REQ-028 SHALL, with IMEM_STALL_INJECT_EN defined, include an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5; advances every cycle), and SHALL additionally force instr_gnt_o=0 when LFSR bit 0 is 1.
REQ-029 SHALL, without IMEM_STALL_INJECT_EN, contain no LFSR and behave exactly as REQ-014.

Verification
REQ-030 SHALL cover this scenario: LATENCY=1, preload word 0 with 32'h0000_0513, req addr 0x0 -> gnt in the same cycle; rvalid one cycle later with rdata 32'h0000_0513 and err 0.
REQ-031 SHALL cover this scenario: LATENCY=2, MAX_OUTSTANDING=2, req held at 0x0, 0x4, 0x8 on consecutive cycles -> first two granted, third gnt=0 until the first rvalid retires, then granted; responses in order.
REQ-032 SHALL cover this scenario: BASE_ADDR=32'h8000_0000, req 32'h7FFF_FFFC and 32'h8000_1000 (DEPTH_WORDS=1024) -> both return err=1, rdata=0.
REQ-033 SHALL cover this scenario: req addr 0x6 -> rdata equals word at 0x4, err=0.
REQ-034 SHALL cover this scenario: load 32'hDEAD_BEEF to 0x10 on the same edge as accepted read of 0x10 holding 32'h1111_1111 -> 32'h1111_1111 returned; a later read returns 32'hDEAD_BEEF.
REQ-035 SHALL cover this scenario: LATENCY=3, two requests in flight, rstn pulsed low -> no rvalid after release, counter 0, gnt=1 on the first post-reset req.
